// File: rtl/cpu_mult_arbiter_if.sv
// cpu_mult_arbiter_if: request, multiplier-cell and response signals of the
// two-requester multiplier arbiter. The slave modport is the arbiter's view,
// the master modport is the environment (requesters, multiplier cell,
// response consumer).
interface cpu_mult_arbiter_if;
    logic        r0_valid;
    logic        r1_valid;
    logic [31:0] r0_src1;
    logic [31:0] r0_src2;
    logic [31:0] r1_src1;
    logic [31:0] r1_src2;
    logic        r0_ready;
    logic        r1_ready;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic [31:0] mul_result;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_ready;

    modport slave (
        input  r0_valid, r1_valid, r0_src1, r0_src2, r1_src1, r1_src2,
        output r0_ready, r1_ready,
        output mul_src1, mul_src2,
        input  mul_result,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready
    );

    modport master (
        output r0_valid, r1_valid, r0_src1, r0_src2, r1_src1, r1_src2,
        input  r0_ready, r1_ready,
        input  mul_src1, mul_src2,
        output mul_result,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready
    );
endinterface

// File: rtl/cpu_mult_arbiter.sv
// cpu_mult_arbiter: shares one pipelined 32-bit multiplier cell between two
// requesters. Accepted operations are tagged with their requester id, the tag
// travels alongside the multiplier pipeline, and results are collected in a
// small in-order FIFO of depth MUL_LATENCY+1 whose head drives the response
// port from registers. A credit check counting in-flight and buffered
// operations guarantees the FIFO never overflows.
// Build option: define CPU_MULT_ARB_FIXED_PRIO_EN to replace round-robin
// arbitration with fixed priority (requester 0 wins when both are valid).
module cpu_mult_arbiter #(
    parameter int MUL_LATENCY = 1   // legal range 1..4
) (
    input  logic              clk,
    input  logic              reset_n,
    cpu_mult_arbiter_if.slave bus
);
    localparam int DEPTH = MUL_LATENCY + 1;
    localparam int CNT_W = 3;
    localparam int SUM_W = 4;

    logic [MUL_LATENCY-1:0] tag_vld_r;
    logic [MUL_LATENCY-1:0] tag_id_r;
    logic [31:0]            fifo_data_r [DEPTH];
    logic                   fifo_id_r   [DEPTH];
    logic [CNT_W-1:0]       fifo_cnt_r;
    logic                   rsp_valid_r;
`ifndef CPU_MULT_ARB_FIXED_PRIO_EN
    logic                   last_grant_r;
`endif

    logic [CNT_W-1:0] in_flight_s;
    logic [SUM_W-1:0] credit_used_s;
    logic             credit_ok_s;
    logic             pop_s;
    logic             push_s;
    logic             issue_s;
    logic             grant_id_s;
    logic [CNT_W-1:0] wr_idx_s;
    logic [CNT_W-1:0] fifo_cnt_nxt_s;
    logic [31:0]      mul_src1_s;
    logic [31:0]      mul_src2_s;

    // Count operations currently travelling through the multiplier pipeline.
    always_comb begin
        in_flight_s = 3'd0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            if (tag_vld_r[i]) begin
                in_flight_s = in_flight_s + 3'd1;
            end else begin
                in_flight_s = in_flight_s;
            end
        end
    end

    // A result slot must be guaranteed before issuing; a same-cycle pop frees one.
    assign pop_s          = rsp_valid_r & bus.rsp_ready;
    assign push_s         = tag_vld_r[MUL_LATENCY-1];
    assign credit_used_s  = {1'b0, in_flight_s} + {1'b0, fifo_cnt_r} - {3'b000, pop_s};
    assign credit_ok_s    = (credit_used_s < SUM_W'(DEPTH));
    assign issue_s        = reset_n & (bus.r0_valid | bus.r1_valid) & credit_ok_s;
    assign fifo_cnt_nxt_s = fifo_cnt_r + {2'b00, push_s} - {2'b00, pop_s};
    assign wr_idx_s       = fifo_cnt_r - {2'b00, pop_s};

    // Select the requester that wins the multiplier this cycle.
    always_comb begin
        grant_id_s = 1'b0;
        if (bus.r0_valid && bus.r1_valid) begin
`ifdef CPU_MULT_ARB_FIXED_PRIO_EN
            grant_id_s = 1'b0;
`else
            grant_id_s = ~last_grant_r;
`endif
        end else if (bus.r1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // Route the granted operands to the multiplier; zero when nothing issues.
    always_comb begin
        mul_src1_s = 32'd0;
        mul_src2_s = 32'd0;
        if (issue_s) begin
            if (grant_id_s) begin
                mul_src1_s = bus.r1_src1;
                mul_src2_s = bus.r1_src2;
            end else begin
                mul_src1_s = bus.r0_src1;
                mul_src2_s = bus.r0_src2;
            end
        end else begin
            mul_src1_s = 32'd0;
            mul_src2_s = 32'd0;
        end
    end

    assign bus.r0_ready  = issue_s & ~grant_id_s;
    assign bus.r1_ready  = issue_s &  grant_id_s;
    assign bus.mul_src1  = mul_src1_s;
    assign bus.mul_src2  = mul_src2_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = fifo_id_r[0];
    assign bus.rsp_data  = fifo_data_r[0];

`ifndef CPU_MULT_ARB_FIXED_PRIO_EN
    // Remember the last granted requester; reset value lets requester 0 win first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= 1'b1;
        end else if (issue_s) begin
            last_grant_r <= grant_id_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // Tag shift register tracking {issue, id} in step with the multiplier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_vld_r <= {MUL_LATENCY{1'b0}};
            tag_id_r  <= {MUL_LATENCY{1'b0}};
        end else begin
            tag_vld_r[0] <= issue_s;
            tag_id_r[0]  <= grant_id_s;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_id_r[i]  <= tag_id_r[i-1];
            end
        end
    end

    // Result FIFO with entry 0 as the registered head; pop shifts, push fills
    // the first free slot after any same-cycle pop so order is preserved.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_r[i] <= 32'd0;
                fifo_id_r[i]   <= 1'b0;
            end
            fifo_cnt_r  <= 3'd0;
            rsp_valid_r <= 1'b0;
        end else begin
            if (pop_s) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    fifo_data_r[i] <= fifo_data_r[i+1];
                    fifo_id_r[i]   <= fifo_id_r[i+1];
                end
            end
            if (push_s) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_idx_s == CNT_W'(i)) begin
                        fifo_data_r[i] <= bus.mul_result;
                        fifo_id_r[i]   <= tag_id_r[MUL_LATENCY-1];
                    end
                end
            end
            fifo_cnt_r  <= fifo_cnt_nxt_s;
            rsp_valid_r <= (fifo_cnt_nxt_s != 3'd0);
        end
    end
endmodule

// File: tb/tb_cpu_mult_arbiter.sv
// tb_cpu_mult_arbiter: scoreboard bench for cpu_mult_arbiter. One instance
// with MUL_LATENCY=1 is checked cycle by cycle against a transaction-level
// reference model (outstanding-operation queue, arbitration rule, response
// availability time); a second instance with MUL_LATENCY=3 checks latency
// and steady throughput. The multiplier cell is modelled as a delay line.
module tb_cpu_mult_arbiter;
    localparam int L1 = 1;
    localparam int D1 = L1 + 1;
    localparam int L3 = 3;
`ifdef CPU_MULT_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cpu_mult_arbiter_if bus1 ();
    cpu_mult_arbiter_if bus3 ();

    cpu_mult_arbiter #(.MUL_LATENCY(L1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    cpu_mult_arbiter #(.MUL_LATENCY(L3)) u_dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

    // Multiplier cell models: low 32 bits of the product, MUL_LATENCY cycles later.
    logic [31:0] m1_r;
    logic [31:0] m3_r [3];
    always @(posedge clk) begin
        m1_r    <= bus1.mul_src1 * bus1.mul_src2;
        m3_r[0] <= bus3.mul_src1 * bus3.mul_src2;
        m3_r[1] <= m3_r[0];
        m3_r[2] <= m3_r[1];
    end
    assign bus1.mul_result = m1_r;
    assign bus3.mul_result = m3_r[2];

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          iss;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    exp_t sb_q[$];
    exp_t q3[$];
    int   last_pop = -100;
    logic last_g = 1'b1;

    logic        act_grants[$];
    int          act_accepts = 0;
    int          act_iss_cyc = 0;
    int          act_rsp_cyc = 0;
    logic [31:0] act_rsp_data = 32'd0;
    logic        act_rsp_id = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares both DUTs against the reference each cycle.
    always @(negedge clk) begin : monitor
        bit v0, v1, rv, pop, iss, g;
        int avail;
        logic [31:0] ea, eb;
        exp_t e;
        cyc = cyc + 1;
        if (reset_n && mon_en) begin
            v0 = bus1.r0_valid;
            v1 = bus1.r1_valid;
            rv = 1'b0;
            if (sb_q.size() > 0) begin
                avail = sb_q[0].iss + L1 + 1;
                if (last_pop + 1 > avail) avail = last_pop + 1;
                rv = (cyc >= avail);
            end
            check("rsp_valid", 32'(bus1.rsp_valid), 32'(rv));
            if (rv) begin
                check("rsp_id", 32'(bus1.rsp_id), 32'(sb_q[0].id));
                check("rsp_data", bus1.rsp_data, sb_q[0].data);
            end
            pop = rv && bus1.rsp_ready;
            iss = (v0 || v1) && ((sb_q.size() - int'(pop)) < D1);
            if (v0 && v1) g = FIXED_PRIO ? 1'b0 : ~last_g;
            else g = v1;
            ea = 32'd0;
            eb = 32'd0;
            if (iss) begin
                ea = g ? bus1.r1_src1 : bus1.r0_src1;
                eb = g ? bus1.r1_src2 : bus1.r0_src2;
            end
            check("r0_ready", 32'(bus1.r0_ready), 32'(iss && !g));
            check("r1_ready", 32'(bus1.r1_ready), 32'(iss && g));
            check("mul_src1", bus1.mul_src1, ea);
            check("mul_src2", bus1.mul_src2, eb);
            if (pop) begin
                void'(sb_q.pop_front());
                last_pop = cyc;
            end
            if (iss) begin
                e.id = g;
                e.data = ea * eb;
                e.iss = cyc;
                sb_q.push_back(e);
                last_g = g;
            end
            if (bus1.r0_valid && bus1.r0_ready) begin
                act_grants.push_back(1'b0);
                act_accepts++;
                act_iss_cyc = cyc;
            end
            if (bus1.r1_valid && bus1.r1_ready) begin
                act_grants.push_back(1'b1);
                act_accepts++;
                act_iss_cyc = cyc;
            end
            if (bus1.rsp_valid && bus1.rsp_ready) begin
                act_rsp_cyc = cyc;
                act_rsp_data = bus1.rsp_data;
                act_rsp_id = bus1.rsp_id;
            end
        end
        if (reset_n) begin
            if (bus3.rsp_valid && bus3.rsp_ready) begin
                if (q3.size() == 0) begin
                    check("stale_l3", 32'(bus3.rsp_valid), 32'd0);
                end else begin
                    e = q3.pop_front();
                    check("rsp_data_l3", bus3.rsp_data, e.data);
                    check("rsp_id_l3", 32'(bus3.rsp_id), 32'd0);
                    check("latency_l3", 32'(cyc - e.iss), 32'(L3 + 1));
                end
            end
            if (bus3.r0_valid && bus3.r0_ready) begin
                e.id = 1'b0;
                e.data = bus3.r0_src1 * bus3.r0_src2;
                e.iss = cyc;
                q3.push_back(e);
            end
        end
    end

    // One cycle of requester/consumer activity on the MUL_LATENCY=1 instance;
    // a requester holds valid and operands until it is accepted.
    task automatic tick(input bit w0, input bit w1, input bit rr,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1);
        bit t0, t1;
        if (!bus1.r0_valid && w0) begin
            bus1.r0_valid = 1'b1;
            bus1.r0_src1 = a0;
            bus1.r0_src2 = b0;
        end
        if (!bus1.r1_valid && w1) begin
            bus1.r1_valid = 1'b1;
            bus1.r1_src1 = a1;
            bus1.r1_src2 = b1;
        end
        bus1.rsp_ready = rr;
        @(negedge clk);
        t0 = bus1.r0_valid && bus1.r0_ready;
        t1 = bus1.r1_valid && bus1.r1_ready;
        @(posedge clk);
        #1;
        if (t0) bus1.r0_valid = 1'b0;
        if (t1) bus1.r1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    logic exp_g[4];
    int   base;
    bit   t3;

    initial begin
        bus1.r0_valid = 1'b1; bus1.r0_src1 = 32'd3; bus1.r0_src2 = 32'd5;
        bus1.r1_valid = 1'b0; bus1.r1_src1 = 32'd0; bus1.r1_src2 = 32'd0;
        bus1.rsp_ready = 1'b1;
        bus3.r0_valid = 1'b0; bus3.r0_src1 = 32'd0; bus3.r0_src2 = 32'd0;
        bus3.r1_valid = 1'b0; bus3.r1_src1 = 32'd0; bus3.r1_src2 = 32'd0;
        bus3.rsp_ready = 1'b0;

        // Reset state, with a request pending to show ready is held low.
        repeat (2) @(posedge clk);
        #1;
        check("reset_r0_ready", 32'(bus1.r0_ready), 32'd0);
        check("reset_r1_ready", 32'(bus1.r1_ready), 32'd0);
        check("reset_mul_src1", bus1.mul_src1, 32'd0);
        check("reset_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(bus1.rsp_id), 32'd0);
        check("reset_rsp_data", bus1.rsp_data, 32'd0);
        reset_n = 1'b1;
        mon_en = 1'b1;

        // 3 x 5 issued in the first cycle after reset.
        tick(1'b1, 1'b0, 1'b1, 32'd3, 32'd5, 32'd0, 32'd0);
        idle(4);
        check("lat_3x5", 32'(act_rsp_cyc - act_iss_cyc), 32'(L1 + 1));
        check("data_3x5", act_rsp_data, 32'd15);
        check("id_3x5", 32'(act_rsp_id), 32'd0);

        // Both requesters valid for four cycles, after a requester 1 grant.
        tick(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd7, 32'd9);
        idle(3);
        base = act_grants.size();
        exp_g[0] = 1'b0; exp_g[1] = FIXED_PRIO ? 1'b0 : 1'b1;
        exp_g[2] = 1'b0; exp_g[3] = FIXED_PRIO ? 1'b0 : 1'b1;
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom);
        for (int k = 0; k < 4; k++) begin
            if (base + k < act_grants.size())
                check($sformatf("grant_%0d", k), 32'(act_grants[base + k]), 32'(exp_g[k]));
            else
                check("grant_count", 32'(act_grants.size() - base), 32'd4);
        end
        idle(8);

        // Backpressure: exactly D accepts, then resume on the first pop.
        base = act_accepts;
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 1'b0, $urandom, $urandom, 32'd0, 32'd0);
        check("stall_accepts", 32'(act_accepts - base), 32'(D1));
        tick(1'b1, 1'b0, 1'b1, $urandom, $urandom, 32'd0, 32'd0);
        check("resume_accepts", 32'(act_accepts - base), 32'(D1 + 1));
        idle(6);

        // Back-to-back wrap-around products from requester 1.
        base = act_accepts;
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd2);
        check("b2b_accepts", 32'(act_accepts - base), 32'd8);
        idle(4);
        check("wrap_data", act_rsp_data, 32'hFFFF_FFFE);

        // Reset with two operations outstanding, last grant to requester 0.
        tick(1'b1, 1'b0, 1'b1, $urandom, $urandom, 32'd0, 32'd0);
        tick(1'b1, 1'b0, 1'b0, $urandom, $urandom, 32'd0, 32'd0);
        tick(1'b1, 1'b0, 1'b0, $urandom, $urandom, 32'd0, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        sb_q.delete();
        last_g = 1'b1;
        last_pop = -100;
        bus1.r0_valid = 1'b1; bus1.r0_src1 = $urandom; bus1.r0_src2 = $urandom;
        bus1.r1_valid = 1'b1; bus1.r1_src1 = $urandom; bus1.r1_src2 = $urandom;
        bus1.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        base = act_grants.size();
        tick(1'b1, 1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom);
        if (base < act_grants.size())
            check("post_reset_grant", 32'(act_grants[base]), 32'd0);
        else
            check("post_reset_issue", 32'(act_grants.size() - base), 32'd1);
        idle(6);

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 300; k++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 $urandom, $urandom, $urandom, $urandom);
        idle(10);

        // MUL_LATENCY=3 instance: continuous requester 0, one issue per cycle.
        bus3.rsp_ready = 1'b1;
        bus3.r0_src1 = $urandom;
        bus3.r0_src2 = $urandom;
        bus3.r0_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("r0_ready_l3", 32'(bus3.r0_ready), 32'd1);
            t3 = bus3.r0_valid && bus3.r0_ready;
            @(posedge clk);
            #1;
            if (t3) begin
                bus3.r0_src1 = $urandom;
                bus3.r0_src2 = $urandom;
            end
        end
        bus3.r0_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pending_l3", 32'(q3.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
